b1_resp_decoder: RTL and testbench

//  Receive side of the b1 benchmark interface. It consumes streamed b1 response

---
 rtl/b1_resp_decoder.sv | 137 +++++++++++++
 tb/tb_b1_resp_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b1_resp_decoder.sv
// rtl/b1_resp_decoder.sv - b1 response decoder: FIFO of {d,e,f,g} words, emits every {a,b,c} preimage.
// Optional B1_RESP_DROP_ERR_EN: error responses are counted but produce no vector beat.
module b1_resp_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [3:0]       resp_data,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [2:0]       vec_data,
    output logic             vec_last,
    output logic             vec_ambig,
    output logic             vec_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ambig_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;
    state_t state, state_n;

    logic [3:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, load;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign resp_ready = !full;
    assign push       = resp_valid && !full;

    logic [3:0] head;
    logic       hd_d, hd_e, hd_f, hd_g, hd_err, hd_ambig, hd_b;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign {hd_d, hd_e, hd_f, hd_g} = head;
    assign hd_err   = (hd_g == hd_d) || (hd_e && hd_f);
    assign hd_ambig = hd_e && !hd_err;
    assign hd_b     = hd_f ^ hd_d;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= resp_data;
    end

    logic       valid_n, last_n, ambig_n, err_n;
    logic [2:0] data_n;

    always_comb begin
        state_n = state;
        valid_n = vec_valid;
        data_n  = vec_data;
        last_n  = vec_last;
        ambig_n = vec_ambig;
        err_n   = vec_err;
        load    = 1'b0;
        case (state)
            IDLE: load = !empty;
            FIRST: begin
                if (vec_ready) begin
                    if (vec_ambig) begin
                        state_n = SECOND;
                        data_n  = {2'b01, vec_data[0]};
                        last_n  = 1'b1;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            SECOND: begin
                if (vec_ready) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
        if (load) begin
            state_n = FIRST;
            valid_n = 1'b1;
            last_n  = !hd_ambig;
            ambig_n = hd_ambig;
            err_n   = hd_err;
            if (hd_err)        data_n = {2'b00, hd_d};
            else if (hd_ambig) data_n = {2'b10, hd_d};
            else               data_n = {hd_b, hd_b, hd_d};
`ifdef B1_RESP_DROP_ERR_EN
            err_n = 1'b0;
            if (hd_err) begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            vec_valid <= 1'b0;
            vec_data  <= '0;
            vec_last  <= 1'b0;
            vec_ambig <= 1'b0;
            vec_err   <= 1'b0;
            err_cnt   <= '0;
            ambig_cnt <= '0;
        end else begin
            state     <= state_n;
            vec_valid <= valid_n;
            vec_data  <= data_n;
            vec_last  <= last_n;
            vec_ambig <= ambig_n;
            vec_err   <= err_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            // Counters stick at all-ones rather than wrapping.
            if (load && hd_err && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
            if (load && hd_ambig && (ambig_cnt != '1))
                ambig_cnt <= ambig_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_b1_resp_decoder.sv
// tb/tb_b1_resp_decoder.sv - directed self-checking bench for b1_resp_decoder.
module tb_b1_resp_decoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             resp_valid = 1'b0;
    logic             resp_ready;
    logic [3:0]       resp_data = 4'h0;
    logic             vec_valid;
    logic             vec_ready = 1'b0;
    logic [2:0]       vec_data;
    logic             vec_last, vec_ambig, vec_err;
    logic [CNT_W-1:0] err_cnt, ambig_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    b1_resp_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .vec_last(vec_last), .vec_ambig(vec_ambig), .vec_err(vec_err),
        .err_cnt(err_cnt), .ambig_cnt(ambig_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {valid, data, last, ambig, err}
    function automatic logic [6:0] vec_now();
        return {vec_valid, vec_data, vec_last, vec_ambig, vec_err};
    endfunction

    // Stimulus only: presents one word and holds it until accepted (bounded).
    task automatic push_word(input logic [3:0] w);
        int waited = 0;
        resp_valid = 1'b1;
        resp_data  = w;
        while (!resp_ready && waited < 50) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        if (!resp_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: resp_ready=%b required 1", resp_ready);
        end
        @(posedge clk); @(negedge clk);
        resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({vec_now(), err_cnt, ambig_cnt, resp_ready} !== {7'b0, 2'b0, 2'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got %b %0d %0d rdy=%b required 0000000 0 0 rdy=1",
                     vec_now(), err_cnt, ambig_cnt, resp_ready);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        vec_ready = 1'b1;
        resp_valid = 1'b1; resp_data = 4'b0011;
        @(posedge clk); @(negedge clk);
        resp_valid = 1'b0;
        n_cmp++;
        if (vec_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_early: vec_valid=%b required 0", vec_valid);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_now() !== 7'b1_110_1_0_0) begin
            n_bad++; $display("FAIL single_vec: got %b required 1110100", vec_now());
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_idle: vec_valid=%b required 0", vec_valid);
        end
    endtask

    task automatic test_back_to_back();
        vec_ready = 1'b1;
        resp_valid = 1'b1; resp_data = 4'b1010;
        @(posedge clk); @(negedge clk);
        resp_data = 4'b0001;
        @(posedge clk); @(negedge clk);
        resp_valid = 1'b0;
        n_cmp++;
        if (vec_now() !== 7'b1_001_1_0_0) begin
            n_bad++; $display("FAIL b2b_first: got %b required 1001100", vec_now());
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_now() !== 7'b1_000_1_0_0) begin
            n_bad++; $display("FAIL b2b_second: got %b required 1000100", vec_now());
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: vec_valid=%b required 0", vec_valid);
        end
    endtask

    task automatic test_ambig();
        vec_ready = 1'b1;
        push_word(4'b1100);
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({vec_now(), ambig_cnt} !== {7'b1_101_0_1_0, 2'd1}) begin
            n_bad++; $display("FAIL ambig_beat1: got %b cnt=%0d required 1101010 cnt=1", vec_now(), ambig_cnt);
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_now() !== 7'b1_011_1_1_0) begin
            n_bad++; $display("FAIL ambig_beat2: got %b required 1011110", vec_now());
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if ({vec_valid, ambig_cnt} !== {1'b0, 2'd1}) begin
            n_bad++; $display("FAIL ambig_end: valid=%b cnt=%0d required 0 1", vec_valid, ambig_cnt);
        end
    endtask

    task automatic test_err();
        vec_ready = 1'b1;
        push_word(4'b0000);
        @(posedge clk); @(negedge clk);
`ifdef B1_RESP_DROP_ERR_EN
        n_cmp++;
        if ({vec_valid, vec_err, err_cnt} !== {1'b0, 1'b0, 2'd1}) begin
            n_bad++; $display("FAIL err_drop: valid=%b err=%b cnt=%0d required 0 0 1", vec_valid, vec_err, err_cnt);
        end
`else
        n_cmp++;
        if ({vec_now(), err_cnt} !== {7'b1_000_1_0_1, 2'd1}) begin
            n_bad++; $display("FAIL err_vec: got %b cnt=%0d required 1000101 cnt=1", vec_now(), err_cnt);
        end
`endif
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_valid !== 1'b0) begin
            n_bad++; $display("FAIL err_idle: vec_valid=%b required 0", vec_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] words [5];
        logic [2:0] exp_v [5];
        words = '{4'b0011, 4'b1010, 4'b0001, 4'b0011, 4'b1010};
        exp_v = '{3'b110, 3'b001, 3'b000, 3'b110, 3'b001};
        vec_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            resp_valid = 1'b1; resp_data = words[i];
            n_cmp++;
            if (resp_ready !== 1'b1) begin
                n_bad++; $display("FAIL bp_accept%0d: resp_ready=%b required 1", i, resp_ready);
            end
            @(posedge clk); @(negedge clk);
        end
        resp_valid = 1'b0;
        n_cmp++;
        if ({resp_ready, vec_now()} !== {1'b0, 7'b1_110_1_0_0}) begin
            n_bad++; $display("FAIL bp_full: rdy=%b vec=%b required 0 1110100", resp_ready, vec_now());
        end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        n_cmp++;
        if ({resp_ready, vec_now()} !== {1'b0, 7'b1_110_1_0_0}) begin
            n_bad++; $display("FAIL bp_stall: rdy=%b vec=%b required 0 1110100", resp_ready, vec_now());
        end
        vec_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            n_cmp++;
            if ({vec_valid, vec_data, vec_last} !== {1'b1, exp_v[i], 1'b1}) begin
                n_bad++; $display("FAIL bp_drain%0d: got %b%b%b required 1%b1", i, vec_valid, vec_data, vec_last, exp_v[i]);
            end
            @(posedge clk); @(negedge clk);
        end
        n_cmp++;
        if ({vec_valid, resp_ready} !== 2'b01) begin
            n_bad++; $display("FAIL bp_empty: valid=%b rdy=%b required 0 1", vec_valid, resp_ready);
        end
    endtask

    task automatic test_saturate();
        vec_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(4'b1111);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        n_cmp++;
        if ({err_cnt, vec_valid} !== {2'd3, 1'b0}) begin
            n_bad++; $display("FAIL err_saturate: cnt=%0d valid=%b required 3 0", err_cnt, vec_valid);
        end
    endtask

    task automatic test_reset_mid();
        vec_ready = 1'b0;
        resp_valid = 1'b1; resp_data = 4'b1100;
        @(posedge clk); @(negedge clk);
        resp_data = 4'b0001;
        @(posedge clk); @(negedge clk);
        resp_valid = 1'b0;
        n_cmp++;
        if (vec_now() !== 7'b1_101_0_1_0) begin
            n_bad++; $display("FAIL rstmid_beat1: got %b required 1101010", vec_now());
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({vec_now(), err_cnt, ambig_cnt, resp_ready} !== {7'b0, 2'b0, 2'b0, 1'b1}) begin
            n_bad++; $display("FAIL rstmid_clear: got %b %0d %0d rdy=%b required 0000000 0 0 rdy=1",
                              vec_now(), err_cnt, ambig_cnt, resp_ready);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        vec_ready = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        n_cmp++;
        if (vec_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_empty: vec_valid=%b required 0", vec_valid);
        end
        push_word(4'b0011);
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_now() !== 7'b1_110_1_0_0) begin
            n_bad++; $display("FAIL rstmid_next: got %b required 1110100", vec_now());
        end
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (vec_valid !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_only: vec_valid=%b required 0", vec_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_ambig();
        test_err();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
